// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry so in_ready is decoded purely from state flops.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH       = 128,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned       CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 clr_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;
`else
  typedef enum logic [0:0] {StEmpty, StFull} state_e;
`endif

  state_e               state_q;
  logic [WIDTH-1:0]     main_q;
  logic [CNT_WIDTH-1:0] stall_count_q;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0]     skid_q;
`endif

  assign out_valid   = (state_q != StEmpty);
  assign out_data    = main_q;
  assign stall_count = stall_count_q;

`ifdef PIPE_STAGE_REG_SKID_EN
  assign in_ready = (state_q != StSkid);
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= StEmpty;
      main_q  <= RESET_VALUE;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q  <= RESET_VALUE;
`endif
    end else if (flush) begin
      // Both entries are discarded; data registers keep their stale contents.
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_valid) begin
            state_q <= StFull;
            main_q  <= in_data;
          end
        end
        StFull: begin
          if (out_ready) begin
            if (in_valid) begin
              main_q <= in_data;
            end else begin
              state_q <= StEmpty;
            end
          end
`ifdef PIPE_STAGE_REG_SKID_EN
          else if (in_valid) begin
            state_q <= StSkid;
            skid_q  <= in_data;
          end
`endif
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        StSkid: begin
          if (out_ready) begin
            state_q <= StFull;
            main_q  <= skid_q;
          end
        end
`endif
        default: state_q <= StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stall_count_q <= '0;
    end else if (clr_count) begin
      stall_count_q <= '0;
    end else if (out_valid && !out_ready && (stall_count_q != CntMax)) begin
      stall_count_q <= stall_count_q + CntOne;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes expected payloads, a negedge monitor pops them.
module tb_pipe_stage_reg;

  localparam int unsigned W = 128;

  logic           clk = 1'b0;
  logic           areset, flush, in_valid, out_ready, clr_count;
  logic           in_ready, out_valid;
  logic [W-1:0]   in_data, out_data;
  logic [15:0]    stall_count;

  logic           s_flush, s_in_valid, s_out_ready, s_clr_count;
  logic           s_in_ready, s_out_valid;
  logic [7:0]     s_in_data, s_out_data;
  logic [1:0]     s_stall_count;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [W-1:0]   exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE({W{1'b0}}), .CNT_WIDTH(16)) dut (
    .clk(clk), .areset(areset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_count(clr_count), .stall_count(stall_count)
  );

  pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .areset(areset), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .clr_count(s_clr_count), .stall_count(s_stall_count)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an output transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (!areset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_data: got unexpected payload %0h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin : stim
    logic [W-1:0] bp_items [3];
    logic         acc;
    int           idx;
    int           gaps;
    int           not_ready;

    areset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    in_data = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_clr_count = 1'b0;
    s_in_data = '0;
    repeat (2) step();
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_data", out_data, '0);
    check("reset stall_count", W'(stall_count), W'(0));
    areset = 1'b0;
    step();

    // Basic flow: one payload, one-cycle latency.
    in_valid = 1'b1; in_data = {16{8'hA5}}; out_ready = 1'b1;
    exp_q.push_back({16{8'hA5}});
    #1;
    check("basic in_ready", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    check("basic out_valid", W'(out_valid), W'(1));
    check("basic out_data", out_data, {16{8'hA5}});
    step();
    check("basic out_valid drop", W'(out_valid), W'(0));
    check("basic in_ready after", W'(in_ready), W'(1));
    check("basic stall_count", W'(stall_count), W'(0));

    // Back-pressure: 4 stalled edges after 0x1 is loaded.
    bp_items[0] = W'(1); bp_items[1] = W'(2); bp_items[2] = W'(3);
    for (int i = 0; i < 3; i++) exp_q.push_back(bp_items[i]);
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 3 || exp_q.size() > 0); cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? bp_items[idx] : '0;
      #1;
`ifdef PIPE_STAGE_REG_SKID_EN
      if (cyc == 1) check("bp in_ready cyc1", W'(in_ready), W'(1));
`else
      if (cyc == 1) check("bp in_ready cyc1", W'(in_ready), W'(0));
`endif
      if (cyc == 2) check("bp in_ready cyc2", W'(in_ready), W'(0));
      acc = in_valid & in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp all accepted", W'(idx), W'(3));
    check("bp all delivered", W'(exp_q.size()), W'(0));
    check("bp stall_count", W'(stall_count), W'(4));

    // Full throughput: 100 back-to-back transfers.
    gaps = 0; not_ready = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h100 + i);
      exp_q.push_back(W'(32'h100 + i));
      #1;
      if (!in_ready) not_ready++;
      step();
      if (!out_valid) gaps++;
    end
    in_valid = 1'b0;
    step();
    check("thru gaps", W'(gaps), W'(0));
    check("thru in_ready stalls", W'(not_ready), W'(0));
    check("thru delivered", W'(exp_q.size()), W'(0));
    check("thru out_valid drop", W'(out_valid), W'(0));

    // Flush a stalled 0x7 while 0x9 is offered.
    out_ready = 1'b0; clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check("flush pre clr", W'(stall_count), W'(0));
    in_valid = 1'b1; in_data = W'(7);
    exp_q.push_back(W'(7));
    step();
    in_valid = 1'b0;
    step();
    check("flush held out_data", out_data, W'(7));
    check("flush pre stall_count", W'(stall_count), W'(1));
    flush = 1'b1; in_valid = 1'b1; in_data = W'(9);
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush out_valid", W'(out_valid), W'(0));
    check("flush out_data kept", out_data, W'(7));
    check("flush stall_count", W'(stall_count), W'(2));
    out_ready = 1'b1; gaps = 0;
    repeat (3) begin
      step();
      if (out_valid) gaps++;
    end
    check("flush no output", W'(gaps), W'(0));
    out_ready = 1'b0;

    // Saturation and clear on the 2-bit counter instance.
    s_in_valid = 1'b1; s_in_data = 8'h33;
    step();
    s_in_valid = 1'b0;
    repeat (6) step();
    check("sat stall_count", W'(s_stall_count), W'(3));
    check("sat out_data", W'(s_out_data), W'(8'h33));
    s_clr_count = 1'b1;
    step();
    s_clr_count = 1'b0;
    check("clr stall_count", W'(s_stall_count), W'(0));
    step();
    check("post clr stall_count", W'(s_stall_count), W'(1));

    // Async reset between edges with the stage occupied and stalled.
    in_valid = 1'b1; in_data = W'(32'h5A);
    step();
    in_data = W'(32'h5B);
    step();
    check("pre areset stall_count", W'(stall_count), W'(3));
    #2;
    areset = 1'b1;
    #1;
    check("areset out_valid", W'(out_valid), W'(0));
    check("areset out_data", out_data, '0);
    check("areset in_ready", W'(in_ready), W'(1));
    check("areset stall_count", W'(stall_count), W'(0));
    check("areset small stall_count", W'(s_stall_count), W'(0));
    in_valid = 1'b0;
    step();
    areset = 1'b0;
    step();
    check("final queue empty", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register: generalises the fixed 128-bit enable register to WIDTH bits and adds a valid/ready handshake, synchronous flush and a saturating stall counter.
- Sits between processor pipeline stages, e.g. IF/ID or ID/EX.
- Provides back-pressure, so a downstream stall propagates upstream without losing data.
- Optional skid buffer gives a fully registered in_ready at full throughput.

Parameters:
- WIDTH, 128: payload width in bits (1..1024).
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into all data registers on areset.
- CNT_WIDTH, 16: stall counter width (2..32).

Ports:
- clk  input  1  rising-edge clock.
- areset  input  1  asynchronous active-high reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage accepts payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds a valid payload.
- out_ready  input  1  downstream accepts payload this cycle.
- out_data  output  WIDTH  payload to downstream; driven directly from the main data register.
- clr_count  input  1  synchronous clear of stall_count.
- stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset and clocking
  - One clock domain: clk. Reset: areset, asynchronous, active-high.
  - While areset=1: state=EMPTY; main and skid data registers = RESET_VALUE; stall_count=0; out_valid=0; out_data=RESET_VALUE; in_ready=1.
- Transfers
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer occurs when out_valid & out_ready at a rising edge.
  - Data registers load only on an accepted transfer; otherwise they hold.
- Latency: 1 cycle. Data accepted at edge N appears on out_data with out_valid=1 after edge N when the stage was empty.
- Ordering: payload order is strictly preserved. No payload is duplicated or dropped except by flush.
- Base mode (macro absent), states EMPTY and FULL:
  - in_ready = ~out_valid | out_ready (combinational from out_ready).
  - EMPTY: in_valid -> FULL, main<=in_data.
  - FULL: out_ready & in_valid -> FULL, main<=in_data.
  - FULL: out_ready & ~in_valid -> EMPTY.
  - FULL: ~out_ready -> hold.
  - out_valid = (state==FULL).
- Flush
  - Highest priority below areset. At the edge: state->EMPTY. Any same-cycle input is dropped, even if in_valid & in_ready. Data registers hold their contents.
  - out_valid=0 from the next cycle. stall_count is not affected.
- Stall counter
  - Each edge with out_valid=1 & out_ready=0: stall_count+1, saturating at 2^CNT_WIDTH-1 with no wrap.
  - clr_count=1 forces 0 at that edge and overrides a simultaneous increment.
- Changing in_data while in_valid=1 & in_ready=0 has no effect.
- out_data is stable while out_valid=1 & out_ready=0.

Optional Feature:
- Macro: PIPE_STAGE_REG_SKID_EN.
- Defined: adds a WIDTH-bit skid register and a third state, SKID. in_ready = (state != SKID) and is decoded purely from state flops, with no combinational path from out_ready.
  - EMPTY: in_valid -> FULL, main<=in.
  - FULL: in_valid & out_ready -> FULL, main<=in.
  - FULL: in_valid & ~out_ready -> SKID, skid<=in.
  - FULL: ~in_valid & out_ready -> EMPTY.
  - SKID: out_ready -> FULL, main<=skid.
  - SKID: ~out_ready -> hold.
  - Skid register resets to RESET_VALUE. Flush from SKID -> EMPTY, discarding both entries.
  - Sustains 1 transfer/cycle with registered in_ready.
- Undefined: base two-state behaviour; no skid register is instantiated.

Test Plan:
- Reset/basic flow: areset pulse, RESET_VALUE=0, in_valid=1 with in_data=0xA5..A5 for one cycle, out_ready=1 -> out_valid=1 with 0xA5..A5 exactly one cycle after acceptance, then out_valid=0. in_ready=1 throughout; stall_count=0.
- Back-pressure: stream 0x1,0x2,0x3 with out_ready=0 for 4 cycles, then 1 -> base mode: in_ready=0 after 0x1 is held; output order is 0x1,0x2,0x3; stall_count=4. With SKID_EN: 0x2 is absorbed into skid, then in_ready=0.
- Full throughput: in_valid=out_ready=1 for 100 cycles with incrementing data -> 100 in-order outputs, one per cycle, no gaps after the first-cycle latency.
- Flush: hold payload 0x7 stalled, assert flush with in_valid=1 and in_data=0x9 -> next cycle out_valid=0. 0x9 never appears. stall_count keeps its value.
- Counter saturation/clear: CNT_WIDTH=2, stall 6 cycles -> stall_count=3. Assert clr_count in a stalled cycle -> 0.
- Async reset mid-operation: in SKID/FULL state, assert areset between clock edges -> outputs go to reset values immediately, without waiting for clk; in_ready=1.
